spi_mcu_rx: RTL and testbench
=============================

Name: spi_mcu_rx

Overview:
- Oversampled SPI slave receiver for MCU control words, sampling msck/mCS/msdi in the 12 MHz system clock domain.
- Sits directly upstream of the control-word capture register and memory block.
- Emits one 16-bit word plus a single-cycle valid strobe per correctly framed transaction.
- Flags malformed frames so the parameter memory is never written with a partial word.

Parameters:
- WORD_W, 16, bits per MCU frame, shifted MSB first.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (minimum 2).

Ports:
- clk  input  1  system clock, 12 MHz; all logic on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- msck  input  1  MCU SPI clock; asynchronous; mode 0; frequency at most clk/4.
- mCS  input  1  MCU chip select, active-low, asynchronous.
- msdi  input  1  MCU serial data, asynchronous.
- word_out  output  WORD_W  last good received word; held until the next good frame.
- word_valid  output  1  one-cycle strobe; word_out is new on this cycle.
- frame_err  output  1  one-cycle strobe; frame ended with bit count other than WORD_W.

Behaviour:
- Synchronisation:
  - msck, mCS and msdi each pass through SYNC_STAGES flops.
  - Edges are detected from the last synced stage against one extra registered copy.
- Reset (rst=0, async):
  - word_out=0, word_valid=0, frame_err=0.
  - Shift register=0, bit count=0, state=IDLE.
  - Sync flops reset to msck=0, mCS=1, msdi=0.
- FSM states: IDLE, SHIFT.
- IDLE:
  - Synced mCS falling edge -> clear shift register and count, go to SHIFT.
  - msck edges are ignored.
- SHIFT:
  - Synced msck rising edge -> shift register <= {shreg[WORD_W-2:0], msdi_sync}; count increments.
  - Count saturates at WORD_W+1 (5-bit counter for default width).
- Frame end (synced mCS rising edge while in SHIFT) -> go to IDLE the next cycle, then:
  - If count == WORD_W: word_out <= shift register and word_valid=1 for exactly one cycle.
  - Otherwise (under- or overrun): frame_err=1 for one cycle; word_out is unchanged.
- Simultaneous synced msck rise and mCS rise in the same cycle: frame end wins and the final msck edge is discarded.
- mCS low during reset release: stay IDLE until a fresh falling edge; no mid-frame capture.
- Latency: word_valid asserts SYNC_STAGES+2 clk cycles after the mCS rising edge at the pin.
- word_valid and frame_err are never high together; neither is ever high for two consecutive cycles.
- Back-to-back frames with at least 3 clk of mCS high between them are all captured.

Optional Feature:
- Macro: SPI_MCU_RX_GLITCH_FILTER_EN.
- Defined:
  - An msck edge is accepted only after the synced msck holds its new level for 2 consecutive clk cycles.
  - Pulses of 1 clk are rejected.
  - Latency increases by 1 cycle and the maximum msck becomes clk/6.
- Undefined: single-sample edge detection as described in Behaviour.

Decomposition:
- Package spi_mcu_pkg:
  - WORD_W default constant.
  - Count-width constant ($clog2(WORD_W+2)).
  - rx_state_t enum {IDLE, SHIFT}.
- Sub-module sync_edge (SYNC_STAGES parameter):
  - Async-input synchroniser plus rise/fall pulse outputs plus synced level.
  - Instantiated for msck and mCS; msdi uses only the level output.

Test Plan:
- Reset: hold rst=0 with random pins -> all outputs 0; release with mCS=1 -> no strobes for 50 cycles.
- Good frame: send 0xA5C3 at msck=clk/4 -> one word_valid pulse, word_out=0xA5C3, frame_err never asserted.
- Short frame: 15 bits then mCS high -> one frame_err pulse, word_out keeps its previous 0xA5C3.
- Long frame: 17 bits of 0xFFFF, 1 -> frame_err pulse, no word_valid, word_out unchanged.
- Back-to-back: 0x1234 then 0xBEEF with 3-clk mCS gap -> two word_valid pulses, in order.
- Mid-frame reset: rst=0 after 8 bits, release with mCS still low, finish frame -> no strobe; next full frame 0x00FF is captured correctly.

Source files
------------

// File: rtl/spi_mcu_pkg.sv
// spi_mcu_pkg: shared constants and FSM state type for the MCU SPI receiver
package spi_mcu_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int CNT_W = $clog2(WORD_W_DEF + 2);
  typedef enum logic {IDLE, SHIFT} rx_state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser for an async input with level and rise/fall pulses
module sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] s;
  logic d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= {SYNC_STAGES{RST_VAL}};
      d <= RST_VAL;
    end else begin
      s <= {s[SYNC_STAGES-2:0], a};
      d <= s[SYNC_STAGES-1];
    end
  end
  assign lvl = s[SYNC_STAGES-1];
  assign rise = lvl & ~d;
  assign fall = ~lvl & d;
endmodule

// File: rtl/spi_mcu_rx.sv
// spi_mcu_rx: oversampled mode-0 SPI slave receiver producing one word per good frame.
// Optional msck glitch filter enabled by defining SPI_MCU_RX_GLITCH_FILTER_EN.
module spi_mcu_rx
  import spi_mcu_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msck,
  input  logic              mCS,
  input  logic              msdi,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              frame_err
);
  localparam int CW = $clog2(WORD_W + 2);
  logic sck_lvl, sck_re, sck_rise, cs_lvl, cs_rise, cs_fall, sdi;
  rx_state_t state, state_d;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [SYNC_STAGES:0] rdy;
  logic armed, start, fin, shift_en, pend, ok;
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .a(msck), .lvl(sck_lvl), .rise(sck_re), .fall()
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .a(mCS), .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clk(clk), .rst(rst), .a(msdi), .lvl(sdi), .rise(), .fall()
  );
`ifdef SPI_MCU_RX_GLITCH_FILTER_EN
  logic sck_h, sck_f;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_h <= 1'b0;
      sck_f <= 1'b0;
    end else begin
      sck_h <= sck_lvl;
      if (sck_lvl == sck_h) sck_f <= sck_lvl;
    end
  end
  assign sck_rise = sck_lvl & sck_h & ~sck_f & (sck_re | ~sck_re);
`else
  assign sck_rise = sck_re;
`endif
  // chip select must be seen high after reset before a falling edge can open a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy <= '0;
      armed <= 1'b0;
    end else begin
      rdy <= {rdy[SYNC_STAGES-1:0], 1'b1};
      armed <= armed | (rdy[SYNC_STAGES] & cs_lvl);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    start = (state == IDLE) & cs_fall & armed;
    fin = (state == SHIFT) & cs_rise;
    shift_en = (state == SHIFT) & sck_rise & ~cs_rise;
    state_d = start ? SHIFT : fin ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt <= '0;
    end else if (start) begin
      shreg <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[WORD_W-2:0], sdi};
      cnt <= (cnt == CW'(WORD_W + 1)) ? cnt : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
      ok <= 1'b0;
      word_out <= '0;
      word_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pend <= fin;
      ok <= cnt == CW'(WORD_W);
      word_valid <= pend & ok;
      frame_err <= pend & ~ok;
      if (pend & ok) word_out <= shreg;
    end
  end
endmodule

// File: tb/tb_spi_mcu_rx.sv
// tb_spi_mcu_rx: directed self-checking bench for spi_mcu_rx
module tb_spi_mcu_rx;
  logic clk = 1'b0, rst = 1'b0, msck = 1'b0, mcs = 1'b1, msdi = 1'b0;
  logic [15:0] word_out;
  logic word_valid, frame_err;
  int n_chk = 0, n_fail = 0, nv = 0, nerr = 0, viol = 0;
  logic pv = 1'b0, pe = 1'b0;
  logic [15:0] words[$];
  always #5 clk = ~clk;
  spi_mcu_rx dut (
    .clk(clk), .rst(rst), .msck(msck), .mCS(mcs), .msdi(msdi),
    .word_out(word_out), .word_valid(word_valid), .frame_err(frame_err)
  );
  always @(negedge clk) begin
    if (word_valid) begin
      nv++;
      words.push_back(word_out);
    end
    if (frame_err) nerr++;
    if ((word_valid & frame_err) | (word_valid & pv) | (frame_err & pe)) viol++;
    pv = word_valid;
    pe = frame_err;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      msdi = v[i];
      tick(2);
      msck = 1'b1;
      tick(2);
      msck = 1'b0;
    end
  endtask
  task automatic start_frame();
    mcs = 1'b0;
    tick(4);
  endtask
  task automatic end_frame();
    tick(2);
    mcs = 1'b1;
    tick(8);
  endtask
  task automatic frame(input logic [31:0] v, input int n);
    start_frame();
    bits(v, n);
    end_frame();
  endtask
  initial begin
    msck = 1'($urandom);
    mcs = 1'($urandom);
    msdi = 1'($urandom);
    tick(3);
    chk("reset_word", word_out, 0);
    chk("reset_valid", word_valid, 0);
    chk("reset_err", frame_err, 0);
    msck = 1'b0;
    mcs = 1'b1;
    msdi = 1'b0;
    rst = 1'b1;
    tick(50);
    chk("idle_no_valid", nv, 0);
    chk("idle_no_err", nerr, 0);
    start_frame();
    bits(32'hA5C3, 16);
    tick(2);
    mcs = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("latency_early", word_valid, 0);
    @(posedge clk);
    #1 chk("latency_valid", word_valid, 1);
    chk("good_word", word_out, 16'hA5C3);
    tick(8);
    chk("good_count", nv, 1);
    chk("good_no_err", nerr, 0);
    frame(32'h7ABC, 15);
    chk("short_err", nerr, 1);
    chk("short_no_valid", nv, 1);
    chk("short_word_held", word_out, 16'hA5C3);
    frame(32'h1FFFF, 17);
    chk("long_err", nerr, 2);
    chk("long_no_valid", nv, 1);
    chk("long_word_held", word_out, 16'hA5C3);
    start_frame();
    bits(32'h1234, 16);
    tick(2);
    mcs = 1'b1;
    tick(3);
    start_frame();
    bits(32'hBEEF, 16);
    end_frame();
    chk("b2b_count", nv, 3);
    chk("b2b_first", words[1], 16'h1234);
    chk("b2b_second", words[2], 16'hBEEF);
    chk("b2b_word", word_out, 16'hBEEF);
    start_frame();
    bits(32'hAB, 8);
    rst = 1'b0;
    tick(3);
    chk("midrst_word", word_out, 0);
    rst = 1'b1;
    tick(4);
    bits(32'hCD, 8);
    end_frame();
    chk("midrst_no_valid", nv, 3);
    chk("midrst_no_err", nerr, 2);
    frame(32'h00FF, 16);
    chk("after_rst_count", nv, 4);
    chk("after_rst_word", word_out, 16'h00FF);
    chk("strobe_rules", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
